uart_flash_encoder: RTL

UART_FLASH_ENCODER -- requirements
Module: uart_flash_encoder

---
 rtl/uart_flash_encoder.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_flash_encoder.sv
// uart_flash_encoder: frames SPI-flash erase/program/read commands as a byte
// stream for a UART bridge, checks the 8-byte echo answer, and forwards
// read-back data.
// Build option: define UART_FLASH_TIMEOUT_EN to bound the answer/read wait
// to TIMEOUT_CYCLES clocks; without it those states wait indefinitely.
module uart_flash_encoder #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [7:0]  cmd_op_i,
  input  logic [23:0] cmd_addr_i,
  output logic        wr_data_req_o,
  input  logic [7:0]  wr_data_i,
  output logic        uart_tx_en_o,
  output logic [7:0]  uart_txdata_o,
  input  logic        uart_tx_busy_i,
  input  logic        uart_rx_valid_i,
  input  logic [7:0]  uart_rxdata_i,
  output logic [7:0]  rd_data_o,
  output logic        rd_data_valid_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    IDLE, HEAD, OP, ADDR, DATA, WAIT_ANS, READ_DATA, FIN
  } state_t;

  state_t      state;
  logic [7:0]  op;
  logic [23:0] addr;
  logic [8:0]  cnt;
  logic        err_flag;
  logic        tx_taken;
  logic [7:0]  ans_exp;
  logic        rx_mismatch;
  logic        tmo_hit;

  // Fixed 7-byte frame header; also the first 7 bytes of every answer.
  function automatic logic [7:0] head_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    head_byte = 8'h36;
      3'd1:    head_byte = 8'h66;
      3'd2:    head_byte = 8'h6C;
      3'd3:    head_byte = 8'h61;
      3'd4:    head_byte = 8'h73;
      3'd5:    head_byte = 8'h68;
      default: head_byte = 8'h36;
    endcase
  endfunction

  function automatic logic op_valid(input logic [7:0] o);
    case (o)
      8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h20: op_valid = 1'b1;
      default:                                  op_valid = 1'b0;
    endcase
  endfunction

  assign tx_taken = uart_tx_en_o && !uart_tx_busy_i;

  // The page-data pop is combinational so the popped byte is loaded into the
  // tx register on the same edge the previous byte is taken: no gap cycles.
  assign wr_data_req_o = tx_taken && (op == 8'h10) &&
                         (((state == ADDR) && (cnt == 9'd2)) ||
                          ((state == DATA) && (cnt != 9'd256)));

  assign ans_exp     = (cnt < 9'd7) ? head_byte(cnt[2:0]) : op;
  assign rx_mismatch = (uart_rxdata_i != ans_exp);

`ifdef UART_FLASH_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // Idle-cycle counter for the answer/read wait; restarts on every rx byte.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tmo_cnt <= 32'd0;
    end else if (((state == WAIT_ANS) || (state == READ_DATA)) && !uart_rx_valid_i) begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end else begin
      tmo_cnt <= 32'd0;
    end
  end

  assign tmo_hit = ((state == WAIT_ANS) || (state == READ_DATA)) && !uart_rx_valid_i &&
                   (tmo_cnt == TIMEOUT_CYCLES - 32'd1);
`else
  assign tmo_hit = 1'b0;
`endif

  // Command sequencer: all outputs except wr_data_req_o are registered here.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state           <= IDLE;
      op              <= 8'h00;
      addr            <= 24'h000000;
      cnt             <= 9'd0;
      err_flag        <= 1'b0;
      cmd_ready_o     <= 1'b1;
      uart_tx_en_o    <= 1'b0;
      uart_txdata_o   <= 8'h00;
      rd_data_o       <= 8'h00;
      rd_data_valid_o <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
    end else begin
      done_o          <= 1'b0;
      err_o           <= 1'b0;
      rd_data_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            op          <= cmd_op_i;
            addr        <= cmd_addr_i;
            cmd_ready_o <= 1'b0;
            cnt         <= 9'd0;
            if (op_valid(cmd_op_i)) begin
              state         <= HEAD;
              uart_tx_en_o  <= 1'b1;
              uart_txdata_o <= head_byte(3'd0);
            end else begin
              // Unknown opcode: report failure next cycle without any traffic.
              state  <= FIN;
              done_o <= 1'b1;
              err_o  <= 1'b1;
            end
          end
        end
        HEAD: begin
          if (tx_taken) begin
            if (cnt == 9'd6) begin
              state         <= OP;
              cnt           <= 9'd0;
              uart_txdata_o <= op;
            end else begin
              cnt           <= cnt + 9'd1;
              uart_txdata_o <= head_byte(cnt[2:0] + 3'd1);
            end
          end
        end
        OP: begin
          if (tx_taken) begin
            cnt <= 9'd0;
            if (op == 8'h00) begin
              // Chip erase carries no address.
              state        <= WAIT_ANS;
              uart_tx_en_o <= 1'b0;
            end else begin
              state         <= ADDR;
              uart_txdata_o <= addr[23:16];
            end
          end
        end
        ADDR: begin
          if (tx_taken) begin
            if (cnt == 9'd2) begin
              if (op == 8'h10) begin
                state         <= DATA;
                uart_txdata_o <= wr_data_i;
                cnt           <= 9'd1;
              end else begin
                state        <= (op == 8'h20) ? READ_DATA : WAIT_ANS;
                uart_tx_en_o <= 1'b0;
                cnt          <= 9'd0;
              end
            end else begin
              cnt           <= cnt + 9'd1;
              uart_txdata_o <= (cnt == 9'd0) ? addr[15:8] : addr[7:0];
            end
          end
        end
        DATA: begin
          // cnt = page bytes already loaded into the tx register.
          if (tx_taken) begin
            if (cnt == 9'd256) begin
              state        <= WAIT_ANS;
              uart_tx_en_o <= 1'b0;
              cnt          <= 9'd0;
            end else begin
              uart_txdata_o <= wr_data_i;
              cnt           <= cnt + 9'd1;
            end
          end
        end
        WAIT_ANS: begin
          if (uart_rx_valid_i) begin
            if (rx_mismatch) err_flag <= 1'b1;
            if (cnt == 9'd7) begin
              state  <= FIN;
              done_o <= 1'b1;
              err_o  <= err_flag | rx_mismatch;
            end else begin
              cnt <= cnt + 9'd1;
            end
          end else if (tmo_hit) begin
            err_flag <= 1'b1;
            state    <= FIN;
            done_o   <= 1'b1;
            err_o    <= 1'b1;
          end
        end
        READ_DATA: begin
          if (cnt == 9'd256) begin
            state  <= FIN;
            done_o <= 1'b1;
            err_o  <= err_flag;
          end else if (uart_rx_valid_i) begin
            rd_data_o       <= uart_rxdata_i;
            rd_data_valid_o <= 1'b1;
            cnt             <= cnt + 9'd1;
          end else if (tmo_hit) begin
            err_flag <= 1'b1;
            state    <= FIN;
            done_o   <= 1'b1;
            err_o    <= 1'b1;
          end
        end
        FIN: begin
          state       <= IDLE;
          cmd_ready_o <= 1'b1;
          cnt         <= 9'd0;
          err_flag    <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          cmd_ready_o <= 1'b1;
          cnt         <= 9'd0;
          err_flag    <= 1'b0;
        end
      endcase
    end
  end

endmodule
